// File: rtl/flag_write_arbiter.sv
// Flag write arbiter: shares the Z/V/N flag register between the ALU (A) and
// the shift/MAC unit (B). Overlapping writes are serialised through a
// one-entry deferral buffer that always drains on the following cycle.
// Branch conditions are resolved on the register value with any deferred
// write forwarded over it.
module flag_write_arbiter #(
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [FLAG_W-1:0] a_flags,
  input  logic [FLAG_W-1:0] a_mask,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [FLAG_W-1:0] b_flags,
  input  logic [FLAG_W-1:0] b_mask,
  output logic              b_ready,
  input  logic [FLAG_W-1:0] flag_q,
  output logic [FLAG_W-1:0] flag_d,
  output logic [FLAG_W-1:0] flag_wen,
  input  logic [2:0]        cond,
  output logic              br_taken,
  output logic              pending
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} st_t;

  st_t               st_q, st_d;
  logic [FLAG_W-1:0] buf_flags_q, buf_flags_d;
  logic [FLAG_W-1:0] buf_mask_q, buf_mask_d;
  logic              pri_q, pri_d;    // 0: A wins the next overlap
  logic [FLAG_W-1:0] wen_a, wen_b;
  logic [FLAG_W-1:0] ef;
  logic              z, v, n;

  // Arbitration: pass/merge writes in IDLE, replay the buffer in HOLD
  always_comb begin
    st_d        = st_q;
    buf_flags_d = buf_flags_q;
    buf_mask_d  = buf_mask_q;
    pri_d       = pri_q;
    flag_d      = '0;
    flag_wen    = '0;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    wen_a       = a_valid ? a_mask : '0;
    wen_b       = b_valid ? b_mask : '0;
    if (st_q == HOLD) begin
      flag_d     = buf_flags_q;
      flag_wen   = buf_mask_q;
      buf_mask_d = '0;
      st_d       = IDLE;
    end else begin
      a_ready = a_valid;
      b_ready = b_valid;
      if ((wen_a & wen_b) != '0) begin
        // Overlap: the favoured side writes now, the other is deferred and
        // gets priority on the next overlap.
        st_d = HOLD;
        if (!pri_q) begin
          flag_d      = a_flags;
          flag_wen    = a_mask;
          buf_flags_d = b_flags;
          buf_mask_d  = b_mask;
          pri_d       = 1'b1;
        end else begin
          flag_d      = b_flags;
          flag_wen    = b_mask;
          buf_flags_d = a_flags;
          buf_mask_d  = a_mask;
          pri_d       = 1'b0;
        end
      end else begin
        // Disjoint or single write: each bit comes from its owner
        flag_wen = wen_a | wen_b;
        flag_d   = (a_flags & wen_a) | (b_flags & wen_b);
      end
    end
    if (rst) begin
      flag_d   = '0;
      flag_wen = '0;
      a_ready  = 1'b0;
      b_ready  = 1'b0;
    end
  end

  // State, buffer and priority registers; reset drops any deferred write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= IDLE;
      buf_flags_q <= '0;
      buf_mask_q  <= '0;
      pri_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      buf_flags_q <= buf_flags_d;
      buf_mask_q  <= buf_mask_d;
      pri_q       <= pri_d;
    end
  end

  assign pending = (st_q == HOLD);

  // Effective flags forward the deferred write over the register value
  always_comb begin
    ef = flag_q;
    if (st_q == HOLD) ef = (buf_flags_q & buf_mask_q) | (flag_q & ~buf_mask_q);
  end

  assign z = ef[0];
  assign v = ef[1];
  assign n = ef[2];

  // Branch condition decode on effective flags
  always_comb begin
    br_taken = 1'b0;
    case (cond)
      3'b000: br_taken = ~z;
      3'b001: br_taken = z;
      3'b010: br_taken = ~z & ~n;
      3'b011: br_taken = n;
      3'b100: br_taken = z | ~n;
      3'b101: br_taken = z | n;
      3'b110: br_taken = v;
      default: br_taken = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_flag_write_arbiter.sv
// Bench for flag_write_arbiter: directed scenarios plus random traffic checked
// against a queue-based model of the deferred-write behaviour.
module tb_flag_write_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [2:0] a_flags, a_mask, b_flags, b_mask;
  logic [2:0] flag_q, flag_d, flag_wen, cond;
  logic       br_taken, pending;

  int errs = 0;
  int checks = 0;

  logic [5:0] defq[$];   // deferred writes {flags, mask}
  bit         mpri;      // 1: B wins the next overlap

  flag_write_arbiter #(.FLAG_W(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_flags(a_flags), .a_mask(a_mask), .a_ready(a_ready),
    .b_valid(b_valid), .b_flags(b_flags), .b_mask(b_mask), .b_ready(b_ready),
    .flag_q(flag_q), .flag_d(flag_d), .flag_wen(flag_wen),
    .cond(cond), .br_taken(br_taken), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [2:0] c, input logic [2:0] f);
    logic zz, vv, nn;
    zz = f[0]; vv = f[1]; nn = f[2];
    case (c)
      3'd0: return !zz;
      3'd1: return zz;
      3'd2: return !zz && !nn;
      3'd3: return nn;
      3'd4: return zz || !nn;
      3'd5: return zz || nn;
      3'd6: return vv;
      default: return 1'b1;
    endcase
  endfunction

  task automatic drive(input logic av, input logic [2:0] af, input logic [2:0] am,
                       input logic bv, input logic [2:0] bf, input logic [2:0] bm);
    a_valid = av; a_flags = af; a_mask = am;
    b_valid = bv; b_flags = bf; b_mask = bm;
  endtask

  // One clock: compare outputs with the model at negedge, advance the model
  task automatic cycle();
    logic [2:0] ew, ed, ef;
    logic       ea, eb, ep;
    logic [5:0] ent;
    @(negedge clk);
    ew = 3'b0; ed = 3'b0; ef = flag_q; ent = 6'b0;
    if (defq.size() > 0) begin
      ent = defq.pop_front();
      for (int i = 0; i < 3; i++) if (ent[i]) ef[i] = ent[3+i];
      ew = ent[2:0]; ed = ent[5:3]; ea = 1'b0; eb = 1'b0; ep = 1'b1;
    end else begin
      ea = a_valid; eb = b_valid; ep = 1'b0;
      if (a_valid && b_valid && (a_mask & b_mask) != 3'b0) begin
        if (!mpri) begin
          ew = a_mask; ed = a_flags; defq.push_back({b_flags, b_mask});
        end else begin
          ew = b_mask; ed = b_flags; defq.push_back({a_flags, a_mask});
        end
        mpri = !mpri;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (a_valid && a_mask[i]) begin ew[i] = 1'b1; ed[i] = a_flags[i]; end
          else if (b_valid && b_mask[i]) begin ew[i] = 1'b1; ed[i] = b_flags[i]; end
        end
      end
    end
    chk("wen", flag_wen, ew);
    chk("d", flag_d & ew, ed & ew);
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    chk("pending", pending, ep);
    chk("br_taken", br_taken, cond_ok(cond, ef));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; cond = 3'd7; flag_q = 3'b0; mpri = 1'b0;
    drive(0, 3'b0, 3'b0, 0, 3'b0, 3'b0);
    #12;
    chk("rst_wen", flag_wen, 3'b000);
    chk("rst_pending", pending, 1'b0);
    chk("rst_ardy", a_ready, 1'b0);
    chk("rst_brdy", b_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single producer write
    drive(1, 3'b001, 3'b111, 0, 3'b0, 3'b0);
    #1; chk("single_wen", flag_wen, 3'b111); chk("single_d", flag_d, 3'b001);
    cycle();

    // Disjoint merge
    drive(1, 3'b001, 3'b001, 1, 3'b100, 3'b110);
    #1; chk("merge_wen", flag_wen, 3'b111); chk("merge_d", flag_d, 3'b101);
    cycle();

    // Overlap held across two collisions: A first, then B first
    drive(1, 3'b001, 3'b111, 1, 3'b100, 3'b111);
    #1; chk("ovl0_d", flag_d, 3'b001);
    cycle();
    chk("ovl1_d", flag_d, 3'b100); chk("ovl1_ardy", a_ready, 1'b0);
    cycle();
    chk("ovl2_pending", pending, 1'b0); chk("ovl2_d", flag_d, 3'b100);
    cycle();
    chk("ovl3_d", flag_d, 3'b001);
    cycle();

    // Forwarding of a deferred Z=0 over flag_q Z=1
    drive(1, 3'b001, 3'b001, 1, 3'b000, 3'b001);
    flag_q = 3'b001; cond = 3'b001;
    cycle();                      // pri is back to A: B's write deferred
    chk("fwd_hold_br", br_taken, 1'b0);
    drive(0, 3'b0, 3'b0, 0, 3'b0, 3'b0);
    cycle();
    chk("fwd_idle_br", br_taken, 1'b1);
    cycle();

    // Valid with empty mask
    drive(1, 3'b111, 3'b000, 0, 3'b0, 3'b0);
    #1; chk("m0_ready", a_ready, 1'b1); chk("m0_wen", flag_wen, 3'b000);
    cycle();

    // Reset in HOLD drops the deferred write
    drive(1, 3'b010, 3'b010, 1, 3'b000, 3'b011);
    cycle();
    chk("pre_rst_pending", pending, 1'b1);
    rst = 1'b1; #1;
    chk("rst_hold_pending", pending, 1'b0);
    chk("rst_hold_wen", flag_wen, 3'b000);
    defq.delete(); mpri = 1'b0;
    drive(0, 3'b0, 3'b0, 0, 3'b0, 3'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    cycle();
    cycle();

    // All condition codes against all flag values
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 8; f++) begin
        cond = 3'(c); flag_q = 3'(f);
        cycle();
      end

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 2) != 0, 3'($urandom), 3'($urandom),
            $urandom_range(0, 2) != 0, 3'($urandom), 3'($urandom));
      flag_q = 3'($urandom); cond = 3'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
